lc3b_mem_ctrl: RTL and testbench
================================

// Module: lc3b_mem_ctrl
// PURPOSE
//  Parametrised LC-3b memory subsystem: MAR/MDR registers, byte-addressed storage,
//  and a fixed-latency read/write engine with an R (ready) handshake to the control FSM.
//  Supersedes the fixed 16-bit, ad-hoc-latency memory. Sits between the datapath bus
//  and control store; MDR is driven onto the bus by the datapath's GateMDR mux.
// PARAMETERS
//  ADDR_W      16   byte-address width held in MAR
//  DEPTH_BYTES 256  storage size in bytes (power of 2, even); address wraps modulo DEPTH_BYTES
//  READ_LAT    5    cycles from access start to R for reads (>=1)
//  WRITE_LAT   10   cycles from access start to R for writes (>=1)
// PORTS
//  clk_50     in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  ld_mar     in   1       load MAR from bus_in (ignored unless IDLE)
//  ld_mdr     in   1       load MDR from bus_in (ignored unless IDLE)
//  mio_en     in   1       start/hold memory access
//  r_w        in   1       1 = write, 0 = read; sampled at access start
//  data_size  in   1       1 = byte, 0 = word; sampled at access start
//  bus_in     in   16      datapath bus
//  mar_out    out  ADDR_W  current MAR
//  mdr_out    out  16      current MDR
//  r          out  1       ready: access complete
//  busy       out  1       high in RD_WAIT/WR_WAIT
//  unaligned  out  1       (MEM_ALIGN_CHECK_EN only) word access with MAR[0]=1
// BEHAVIOUR
//  Reset: state IDLE; mar_out=0, mdr_out=0, r=0, busy=0, unaligned=0, counter=0. Storage is not cleared.
//  FSM: IDLE -> RD_WAIT|WR_WAIT -> DONE -> IDLE.
//   IDLE: mio_en=1 starts access; latch r_w/data_size; counter <= LAT-1; busy=1 next cycle.
//         ld_mar/ld_mdr act only in IDLE; same-edge ld_mar+mio_en uses the OLD MAR.
//   *_WAIT: counter decrements; at counter==0 perform access, enter DONE. Read latency to r=1 = READ_LAT cycles after start edge.
//   DONE: r=1; stay while mio_en=1; -> IDLE when mio_en=0 (no re-trigger without mio_en dropping).
//   mio_en falling mid-WAIT does NOT abort; access completes, DONE exits after 1 cycle.
//  Endianness: little-endian. Word at A = {mem[A|1], mem[A&~1]}; word accesses ignore MAR[0].
//  Read byte: mdr <= sign-extend(mem[A]) to 16 bits. Read word: mdr <= word.
//  Write byte: mem[A] <= mdr[7:0]. Write word: both bytes, in the same cycle.
//  Address index = MAR mod DEPTH_BYTES (upper bits ignored, wrap-around).
//  MDR updated from memory only on read completion edge; same edge as r rising.
//  Reset asserted mid-access: access dropped, no partial write, outputs to reset values.
// CONFIGURATION
//  `MEM_ALIGN_CHECK_EN defined: unaligned=1 in DONE for word access with MAR[0]=1;
//   the access is still performed force-aligned. Undefined: port absent, no check logic.
// STRUCTURE
//  lc3b_mem_defs.vh: state encodings (S_IDLE,S_RD_WAIT,S_WR_WAIT,S_DONE), DS_BYTE/DS_WORD, RW_READ/RW_WRITE.
//  Sub-module lc3b_mem_array: byte-lane RAM, two byte write enables, even/odd lanes,
//   combinational read; controller owns FSM, counter, MAR/MDR, sign extension.
// TESTING
//  1 Word write/read: MAR=0x0010, MDR=0x1234, r_w=1 -> r after 10 cycles; read -> mdr=0x1234 after 5.
//  2 Byte sign-ext: write byte 0x85 to 0x0021; byte read -> mdr=0xFF85; word read 0x0020 -> mdr[15:8]=0x85.
//  3 Wrap: DEPTH_BYTES=256, write word 0xBEEF at 0x0104 -> word read at 0x0004 returns 0xBEEF.
//  4 Handshake: hold mio_en 3 cycles after r -> r stays high, no second access; drop -> IDLE next cycle.
//  5 Reset mid-write: rst_n low at WAIT count 4 -> r=0,busy=0,mdr=0; target bytes unchanged.
//  6 MEM_ALIGN_CHECK_EN: word read at 0x0011 -> unaligned=1 with r, data = word at 0x0010.

Source files
------------

// File: rtl/lc3b_mem_ctrl_pkg.sv
// lc3b_mem_ctrl_pkg: shared definitions for the LC-3b memory subsystem.
//   state_t            controller states (S_IDLE, S_RD_WAIT, S_WR_WAIT, S_DONE)
//   DS_BYTE / DS_WORD  data_size encodings
//   RW_READ / RW_WRITE r_w encodings
//   sext8()            sign-extend a byte to a 16-bit bus value
package lc3b_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic DS_WORD  = 1'b0;
    localparam logic DS_BYTE  = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array: byte-lane storage split into even and odd byte lanes.
//   clk_50   in  write clock
//   word_idx in  word index (byte address with bit 0 dropped, already wrapped)
//   we_even  in  write wdata[7:0] into the even lane
//   we_odd   in  write wdata[15:8] into the odd lane
//   wdata    in  write data, low byte -> even lane, high byte -> odd lane
//   rd_even  out combinational even-lane byte at word_idx
//   rd_odd   out combinational odd-lane byte at word_idx
// Storage is never reset.
module lc3b_mem_array #(
    parameter int DEPTH_BYTES = 256,
    parameter int WORD_AW     = $clog2(DEPTH_BYTES) - 1
) (
    input  logic               clk_50,
    input  logic [WORD_AW-1:0] word_idx,
    input  logic               we_even,
    input  logic               we_odd,
    input  logic [15:0]        wdata,
    output logic [7:0]         rd_even,
    output logic [7:0]         rd_odd
);

    logic [7:0] even_lane_q [DEPTH_BYTES/2];
    logic [7:0] odd_lane_q  [DEPTH_BYTES/2];

    always_ff @(posedge clk_50) begin
        if (we_even) even_lane_q[word_idx] <= wdata[7:0];
        if (we_odd)  odd_lane_q[word_idx]  <= wdata[15:8];
    end

    assign rd_even = even_lane_q[word_idx];
    assign rd_odd  = odd_lane_q[word_idx];

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl: LC-3b MAR/MDR registers plus fixed-latency memory access engine.
//   clk_50    in  system clock
//   rst_n     in  asynchronous active-low reset
//   ld_mar    in  load MAR from bus_in (IDLE only)
//   ld_mdr    in  load MDR from bus_in (IDLE only)
//   mio_en    in  start / hold a memory access
//   r_w       in  1 = write, 0 = read (sampled at access start)
//   data_size in  1 = byte, 0 = word (sampled at access start)
//   bus_in    in  datapath bus
//   mar_out   out current MAR
//   mdr_out   out current MDR
//   r         out access complete (DONE state)
//   busy      out access in progress (RD_WAIT / WR_WAIT)
//   unaligned out word access with MAR[0]=1, valid with r (only with MEM_ALIGN_CHECK_EN)
// Optional feature macro: MEM_ALIGN_CHECK_EN.
module lc3b_mem_ctrl
    import lc3b_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 256,
    parameter int READ_LAT    = 5,
    parameter int WRITE_LAT   = 10
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic              data_size,
    input  logic [15:0]       bus_in,
    output logic [ADDR_W-1:0] mar_out,
    output logic [15:0]       mdr_out,
    output logic              r,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              busy,
    output logic              unaligned
`else
    output logic              busy
`endif
);

    localparam int IDX_W   = $clog2(DEPTH_BYTES);
    localparam int MAX_LAT = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [15:0]       mdr_q, mdr_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic              fire;
    logic              wr_fire;
    logic              we_even, we_odd;
    logic [7:0]        rd_even, rd_odd;
    logic [15:0]       rd_val, wdata;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= RW_READ;
            size_q  <= DS_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
        end
    end

    // Bytes come from the lane selected by MAR[0]; words ignore MAR[0].
    assign rd_val = size_q == DS_BYTE ? sext8(mar_q[0] ? rd_odd : rd_even) : {rd_odd, rd_even};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A starting access takes priority so it uses the MAR/MDR held
                // before this edge; same-edge loads are dropped.
                if (mio_en) begin
                    state_d = r_w == RW_WRITE ? S_WR_WAIT : S_RD_WAIT;
                    cnt_d   = r_w == RW_WRITE ? WR_INIT : RD_INIT;
                    rw_d    = r_w;
                    size_d  = data_size;
                end else begin
                    mar_d = ld_mar ? ADDR_W'(bus_in) : mar_q;
                    mdr_d = ld_mdr ? bus_in : mdr_q;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                fire    = cnt_q == '0;
                cnt_d   = fire ? cnt_q : cnt_q - CNT_W'(1);
                state_d = fire ? S_DONE : state_q;
                mdr_d   = fire && state_q == S_RD_WAIT ? rd_val : mdr_q;
            end
            S_DONE: state_d = mio_en ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Byte writes replicate the low MDR byte onto both lanes and enable one.
    assign wr_fire = fire && state_q == S_WR_WAIT;
    assign wdata   = size_q == DS_BYTE ? {2{mdr_q[7:0]}} : mdr_q;
    assign we_even = wr_fire && (size_q == DS_WORD || !mar_q[0]);
    assign we_odd  = wr_fire && (size_q == DS_WORD || mar_q[0]);

    lc3b_mem_array #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .WORD_AW    (IDX_W - 1)
    ) u_array (
        .clk_50  (clk_50),
        .word_idx(mar_q[IDX_W-1:1]),
        .we_even (we_even),
        .we_odd  (we_odd),
        .wdata   (wdata),
        .rd_even (rd_even),
        .rd_odd  (rd_odd)
    );

    assign mar_out = mar_q;
    assign mdr_out = mdr_q;
    assign r       = state_q == S_DONE;
    assign busy    = state_q == S_RD_WAIT || state_q == S_WR_WAIT;

`ifdef MEM_ALIGN_CHECK_EN
    assign unaligned = r && size_q == DS_WORD && mar_q[0];
`endif

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl: directed bench with a cycle-stamped behavioural model and per-cycle compare.
module tb_lc3b_mem_ctrl;

    localparam int RL = 5;
    localparam int WL = 10;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
    logic [15:0] bus_in;
    logic [15:0] mar_out, mdr_out;
    logic        r, busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        unaligned;
`endif

    int errors = 0;
    int checks = 0;
    bit run = 0;

    always #5 clk_50 = ~clk_50;

    lc3b_mem_ctrl #(
        .ADDR_W(16), .DEPTH_BYTES(256), .READ_LAT(RL), .WRITE_LAT(WL)
    ) dut (
`ifdef MEM_ALIGN_CHECK_EN
        .unaligned(unaligned),
`endif
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .mio_en   (mio_en),
        .r_w      (r_w),
        .data_size(data_size),
        .bus_in   (bus_in),
        .mar_out  (mar_out),
        .mdr_out  (mdr_out),
        .r        (r),
        .busy     (busy)
    );

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: an access started at edge n completes at edge n+latency;
    // ready then holds until mio_en is seen low.
    int          cyc, m_due, ma, mw;
    bit          m_pend, m_done, m_rw, m_byte;
    logic [15:0] m_mar, m_mdr;
    logic [7:0]  m_mem [256];

    always @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_pend = 0; m_done = 0; m_rw = 0; m_byte = 0;
            m_mar = 0; m_mdr = 0;
        end else begin
            cyc++;
            if (m_pend) begin
                if (cyc == m_due) begin
                    ma = int'(m_mar[7:0]);
                    mw = ma & ~1;
                    if (m_rw && m_byte) m_mem[ma] = m_mdr[7:0];
                    else if (m_rw) begin
                        m_mem[mw] = m_mdr[7:0];
                        m_mem[mw+1] = m_mdr[15:8];
                    end else if (m_byte) m_mdr = {{8{m_mem[ma][7]}}, m_mem[ma]};
                    else m_mdr = {m_mem[mw+1], m_mem[mw]};
                    m_pend = 0;
                    m_done = 1;
                end
            end else if (m_done) begin
                if (!mio_en) m_done = 0;
            end else if (mio_en) begin
                m_pend = 1;
                m_rw   = r_w;
                m_byte = data_size;
                m_due  = cyc + (r_w ? WL : RL);
            end else begin
                if (ld_mar) m_mar = bus_in;
                if (ld_mdr) m_mdr = bus_in;
            end
        end
    end

    always @(negedge clk_50) begin
        if (run) begin
            chk("mar", mar_out, m_mar);
            chk("mdr", mdr_out, m_mdr);
            chk("r", 16'(r), 16'(m_done));
            chk("busy", 16'(busy), 16'(m_pend));
`ifdef MEM_ALIGN_CHECK_EN
            chk("unaligned", 16'(unaligned), 16'(m_done && !m_byte && m_mar[0]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        ld_mar = 1; bus_in = v; tick(); ld_mar = 0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        ld_mdr = 1; bus_in = v; tick(); ld_mdr = 0;
    endtask

    task automatic start_wait(input logic rw, input logic sz, output int lat);
        mio_en = 1; r_w = rw; data_size = sz;
        tick();
        lat = 0;
        while (!r && lat < 50) begin
            tick();
            lat++;
        end
        chk("ready_seen", 16'(r), 16'd1);
    endtask

    task automatic finish_acc(input int hold);
        repeat (hold) begin
            tick();
            chk("hold_r", 16'(r), 16'd1);
            chk("hold_busy", 16'(busy), 16'd0);
        end
        mio_en = 0;
        tick();
        chk("back_idle_r", 16'(r), 16'd0);
    endtask

    task automatic access(input logic rw, input logic sz, output int lat);
        start_wait(rw, sz, lat);
        finish_acc(0);
    endtask

    int lat;

    initial begin
        rst_n = 0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; data_size = 0; bus_in = 0;
        tick();
        run = 1;
        tick();
        chk("rst_mar", mar_out, 16'h0000);
        chk("rst_mdr", mdr_out, 16'h0000);
        chk("rst_r", 16'(r), 16'd0);
        rst_n = 1;
        tick();

        // Word write then word read
        load_mar(16'h0010); load_mdr(16'h1234);
        access(1'b1, 1'b0, lat);
        chk("wr_word_lat", 16'(lat), 16'd10);
        load_mdr(16'h0000);
        access(1'b0, 1'b0, lat);
        chk("rd_word_lat", 16'(lat), 16'd5);
        chk("rd_word_data", mdr_out, 16'h1234);

        // Byte write with sign extension on byte read
        load_mar(16'h0020); load_mdr(16'h1177);
        access(1'b1, 1'b0, lat);
        load_mar(16'h0021); load_mdr(16'h0085);
        access(1'b1, 1'b1, lat);
        access(1'b0, 1'b1, lat);
        chk("rd_byte_sext", mdr_out, 16'hFF85);
        load_mar(16'h0020);
        access(1'b0, 1'b0, lat);
        chk("rd_word_hi", {8'h00, mdr_out[15:8]}, 16'h0085);
        chk("rd_word_full", mdr_out, 16'h8577);

        // Positive byte read at even address
        access(1'b0, 1'b1, lat);
        chk("rd_byte_pos", mdr_out, 16'h0077);

        // Address wrap modulo 256
        load_mar(16'h0104); load_mdr(16'hBEEF);
        access(1'b1, 1'b0, lat);
        load_mar(16'h0004);
        access(1'b0, 1'b0, lat);
        chk("wrap_data", mdr_out, 16'hBEEF);

        // Handshake: hold mio_en three cycles after ready
        load_mar(16'h0010);
        start_wait(1'b0, 1'b0, lat);
        finish_acc(3);
        chk("hold_data", mdr_out, 16'h1234);

        // mio_en dropped mid-wait: access completes, ready lasts one cycle
        load_mar(16'h0104);
        mio_en = 1; r_w = 0; data_size = 0;
        tick();
        mio_en = 0;
        lat = 0;
        while (!r && lat < 50) begin
            tick();
            lat++;
        end
        chk("drop_lat", 16'(lat), 16'd5);
        chk("drop_data", mdr_out, 16'hBEEF);
        tick();
        chk("drop_r_one", 16'(r), 16'd0);

        // Same-edge ld_mar with access start keeps the old MAR
        load_mar(16'h0010);
        ld_mar = 1; bus_in = 16'h0040;
        start_wait(1'b0, 1'b0, lat);
        ld_mar = 0;
        finish_acc(0);
        chk("same_edge_mar", mar_out, 16'h0010);
        chk("same_edge_data", mdr_out, 16'h1234);

        // Reset in the middle of a write leaves target bytes untouched
        load_mar(16'h0030); load_mdr(16'h1111);
        access(1'b1, 1'b0, lat);
        load_mdr(16'h2222);
        mio_en = 1; r_w = 1; data_size = 0;
        tick();
        mio_en = 0;
        repeat (5) tick();
        chk("mid_busy", 16'(busy), 16'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_r", 16'(r), 16'd0);
        chk("rst_mid_busy", 16'(busy), 16'd0);
        chk("rst_mid_mdr", mdr_out, 16'h0000);
        tick();
        rst_n = 1;
        tick();
        load_mar(16'h0030);
        access(1'b0, 1'b0, lat);
        chk("rst_no_write", mdr_out, 16'h1111);

        // Word read at odd address is force-aligned
        load_mar(16'h0011);
        start_wait(1'b0, 1'b0, lat);
        chk("odd_word_data", mdr_out, 16'h1234);
`ifdef MEM_ALIGN_CHECK_EN
        chk("unaligned_flag", 16'(unaligned), 16'd1);
`endif
        finish_acc(0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
